dmem_resp: RTL and testbench

DMEM_RESP -- requirements
Module: dmem_resp

---
 rtl/dmem_resp.sv | 242 ++++++++++++++++++++++++
 tb/tb_dmem_resp.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// dmem_resp: data-memory responder for the MEM stage of a RISC-V pipeline.
// A legal load/store is accepted in IDLE, the pipeline is frozen for LATENCY
// cycles, and the access completes in DONE (store committed on entry, load
// data presented for one cycle). Misaligned or undefined accesses are rejected
// in IDLE with a one-cycle error pulse and no stall.
//
// Ports:
//   clk         in   sole clock, rising edge
//   reset       in   asynchronous, active-high
//   memReadM    in   load request
//   memWriteM   in   store request (wins when both are high)
//   funct3M     in   [2:0] load/store width code
//   aluResultM  in   [31:0] byte address
//   writeDataM  in   [31:0] store data, right-aligned
//   readDataM   out  [31:0] extended load result, nonzero only in DONE
//   stallM      out  pipeline freeze request
//   accessErrM  out  illegal access pulse
//
// state | meaning
// IDLE  | waiting for a request; legal request stalls and latches the access
// BUSY  | access in flight; counter counts remaining BUSY cycles
// DONE  | store already committed; load data on readDataM; back to IDLE
module dmem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memReadM,
  input  logic        memWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] aluResultM,
  input  logic [31:0] writeDataM,
  output logic [31:0] readDataM,
  output logic        stallM,
  output logic        accessErrM
);

  localparam int         AW     = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [1:0]      off_q, off_d;
  logic [31:0]     data_q, data_d;
  logic [2:0]      f3_q, f3_d;
  logic            wr_q, wr_d;
  logic [31:0]     rdata_q, rdata_d;

  logic [31:0]     mem [DEPTH];

  // Address bits above the word index wrap and are deliberately ignored.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^aluResultM[31:AW+2];

  logic            req, req_wr, req_illegal;
  logic            stall_c, err_c, enter_done;

  // Effective access: live inputs in IDLE (only used when LATENCY==1 skips
  // BUSY), latched copy otherwise.
  logic [AW-1:0]   cur_idx;
  logic [1:0]      cur_off;
  logic [31:0]     cur_data;
  logic [2:0]      cur_f3;
  logic            cur_wr;

  logic [31:0]     rd_word, load_val, st_data;
  logic [7:0]      rd_byte;
  logic [15:0]     rd_half;
  logic [3:0]      st_be;
  logic            mem_we;

  function automatic logic is_illegal(input logic wr, input logic [2:0] f3,
                                      input logic [1:0] a);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = a[0];
      3'b010:  bad = (a != 2'b00);
      3'b100:  bad = wr;
      3'b101:  bad = wr | a[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  assign req         = memReadM | memWriteM;
  assign req_wr      = memWriteM;
  assign req_illegal = is_illegal(req_wr, funct3M, aluResultM[1:0]);

  always_comb begin
    if (state_q == IDLE) begin
      cur_idx  = aluResultM[AW+1:2];
      cur_off  = aluResultM[1:0];
      cur_data = writeDataM;
      cur_f3   = funct3M;
      cur_wr   = req_wr;
    end else begin
      cur_idx  = idx_q;
      cur_off  = off_q;
      cur_data = data_q;
      cur_f3   = f3_q;
      cur_wr   = wr_q;
    end
  end

  // Load extraction from the addressed word.
  always_comb begin
    rd_word = mem[cur_idx];
    rd_byte = rd_word[{cur_off, 3'b000} +: 8];
    rd_half = cur_off[1] ? rd_word[31:16] : rd_word[15:0];
    case (cur_f3)
      3'b000:  load_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_val = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_val = rd_word;
      3'b100:  load_val = {24'h0, rd_byte};
      3'b101:  load_val = {16'h0, rd_half};
      default: load_val = 32'h0;
    endcase
  end

  // Store lane replication and byte enables.
  always_comb begin
    case (cur_f3)
      3'b000: begin
        st_data = {4{cur_data[7:0]}};
        st_be   = 4'b0001 << cur_off;
      end
      3'b001: begin
        st_data = {2{cur_data[15:0]}};
        st_be   = cur_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = cur_data;
        st_be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    off_d      = off_q;
    data_d     = data_q;
    f3_d       = f3_q;
    wr_d       = wr_q;
    rdata_d    = 32'h0;
    stall_c    = 1'b0;
    err_c      = 1'b0;
    enter_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (req_illegal) begin
            err_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            idx_d   = aluResultM[AW+1:2];
            off_d   = aluResultM[1:0];
            data_d  = writeDataM;
            f3_d    = funct3M;
            wr_d    = req_wr;
            // The request cycle is the first stall cycle, so BUSY lasts
            // LATENCY-1 cycles; with LATENCY==1 it is skipped entirely.
            if (LATENCY == 1) begin
              state_d    = DONE;
              cnt_d      = 4'd0;
              enter_done = 1'b1;
            end else begin
              state_d = BUSY;
              cnt_d   = LAT_M1;
            end
          end
        end
      end
      BUSY: begin
        stall_c = 1'b1;
        cnt_d   = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = DONE;
          enter_done = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    if (enter_done && !cur_wr) begin
      rdata_d = load_val;
    end
  end

  assign mem_we = enter_done & cur_wr & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      off_q   <= 2'b00;
      data_q  <= 32'h0;
      f3_q    <= 3'b000;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      off_q   <= off_d;
      data_q  <= data_d;
      f3_q    <= f3_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // Array keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (st_be[b]) begin
          mem[cur_idx][8*b +: 8] <= st_data[8*b +: 8];
        end
      end
    end
  end

  // Request-cycle outputs depend on inputs, so reset must mask them directly.
  assign stallM     = stall_c & ~reset;
  assign accessErrM = err_c & ~reset;
  assign readDataM  = rdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
module tb_dmem_resp;

  logic        clk;
  logic        reset;
  logic        memReadM;
  logic        memWriteM;
  logic [2:0]  funct3M;
  logic [31:0] aluResultM;
  logic [31:0] writeDataM;
  logic [31:0] readDataM;
  logic        stallM;
  logic        accessErrM;

  int n_checks = 0;
  int n_errors = 0;

  dmem_resp #(.DEPTH(256), .LATENCY(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .memReadM   (memReadM),
    .memWriteM  (memWriteM),
    .funct3M    (funct3M),
    .aluResultM (aluResultM),
    .writeDataM (writeDataM),
    .readDataM  (readDataM),
    .stallM     (stallM),
    .accessErrM (accessErrM)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic drop_inputs();
    memReadM   = 1'b0;
    memWriteM  = 1'b0;
    funct3M    = 3'b000;
    aluResultM = 32'h0;
    writeDataM = 32'h0;
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    drop_inputs();
    #1;
    chk({tag, "/idle_stall"}, {31'b0, stallM}, 32'h0);
    chk({tag, "/idle_rdata"}, readDataM, 32'h0);
  endtask

  // Drives one request, holds it while stalled, checks stall length and the
  // DONE-cycle read data. Inputs stay asserted after DONE.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic exp_err, input logic [31:0] exp_rd,
                        input string tag);
    int stalls;
    @(negedge clk);
    memReadM   = rd;
    memWriteM  = wr;
    funct3M    = f3;
    aluResultM = addr;
    writeDataM = data;
    #1;
    if (exp_err) begin
      chk({tag, "/err"},   {31'b0, accessErrM}, 32'h1);
      chk({tag, "/stall"}, {31'b0, stallM},     32'h0);
      chk({tag, "/rdata"}, readDataM,           32'h0);
      @(negedge clk);
      drop_inputs();
      #1;
      chk({tag, "/err_pulse"}, {31'b0, accessErrM}, 32'h0);
      chk({tag, "/stall2"},    {31'b0, stallM},     32'h0);
    end else begin
      chk({tag, "/noerr"}, {31'b0, accessErrM}, 32'h0);
      stalls = 0;
      for (int i = 0; i < 20 && stallM; i++) begin
        stalls++;
        chk({tag, "/rdata_stalled"}, readDataM, 32'h0);
        @(negedge clk);
        #1;
      end
      chk({tag, "/stall_cycles"}, stalls,     32'd2);
      chk({tag, "/done_rdata"},   readDataM,  exp_rd);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drop_inputs();
    reset = 1'b1;
    #1;
    chk("rst/stall", {31'b0, stallM},     32'h0);
    chk("rst/err",   {31'b0, accessErrM}, 32'h0);
    chk("rst/rdata", readDataM,           32'h0);
    // Requests during reset must not raise stall or error.
    memReadM = 1'b1; funct3M = 3'b010; aluResultM = 32'h10;
    #1;
    chk("rst/req_stall", {31'b0, stallM}, 32'h0);
    funct3M = 3'b001; aluResultM = 32'h13;
    #1;
    chk("rst/bad_err", {31'b0, accessErrM}, 32'h0);
    drop_inputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    access(0, 1, 3'b010, 32'h10, 32'h12345678, 0, 32'h0,        "sw10");      idle("sw10");
    access(1, 0, 3'b010, 32'h10, 32'h0,        0, 32'h12345678, "lw10");      idle("lw10");
    access(0, 1, 3'b000, 32'h11, 32'h555555AB, 0, 32'h0,        "sb11");      idle("sb11");
    access(1, 0, 3'b000, 32'h11, 32'h0,        0, 32'hFFFFFFAB, "lb11");      idle("lb11");
    access(1, 0, 3'b100, 32'h11, 32'h0,        0, 32'h000000AB, "lbu11");     idle("lbu11");
    access(1, 0, 3'b010, 32'h10, 32'h0,        0, 32'h1234AB78, "lw10b");     idle("lw10b");
    access(1, 0, 3'b000, 32'h10, 32'h0,        0, 32'h00000078, "lb10");      idle("lb10");
    access(0, 1, 3'b001, 32'h12, 32'h7777BEEF, 0, 32'h0,        "sh12");      idle("sh12");
    access(1, 0, 3'b001, 32'h12, 32'h0,        0, 32'hFFFFBEEF, "lh12");      idle("lh12");
    access(1, 0, 3'b101, 32'h12, 32'h0,        0, 32'h0000BEEF, "lhu12");     idle("lhu12");
    access(1, 0, 3'b001, 32'h10, 32'h0,        0, 32'hFFFFAB78, "lh10");      idle("lh10");
    access(1, 0, 3'b010, 32'h10, 32'h0,        0, 32'hBEEFAB78, "lw10c");     idle("lw10c");

    access(1, 0, 3'b001, 32'h13, 32'h0,        1, 32'h0,        "lh13_bad");
    access(0, 1, 3'b010, 32'h20, 32'h11111111, 0, 32'h0,        "sw20");      idle("sw20");
    access(0, 1, 3'b010, 32'h22, 32'h99999999, 1, 32'h0,        "sw22_bad");
    access(1, 0, 3'b011, 32'h20, 32'h0,        1, 32'h0,        "ld011_bad");
    access(0, 1, 3'b100, 32'h20, 32'h88888888, 1, 32'h0,        "st100_bad");
    access(1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h11111111, "lw20");      idle("lw20");

    // Reset while a store is in BUSY aborts it.
    @(negedge clk);
    memWriteM = 1'b1; funct3M = 3'b010; aluResultM = 32'h20; writeDataM = 32'hDEADBEEF;
    #1;
    chk("rstbusy/t0_stall", {31'b0, stallM}, 32'h1);
    @(negedge clk);
    #1;
    chk("rstbusy/busy_stall", {31'b0, stallM}, 32'h1);
    #1;
    reset = 1'b1;
    drop_inputs();
    #1;
    chk("rstbusy/stall_drop", {31'b0, stallM},     32'h0);
    chk("rstbusy/err",        {31'b0, accessErrM}, 32'h0);
    chk("rstbusy/rdata",      readDataM,           32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    access(1, 0, 3'b010, 32'h20, 32'h0,        0, 32'h11111111, "lw20_after_rst"); idle("lw20r");

    // Both strobes high is a write; high address bits wrap.
    access(1, 1, 3'b010, 32'h400, 32'hCAFEF00D, 0, 32'h0,        "both_sw400"); idle("both");
    access(1, 0, 3'b010, 32'h000, 32'h0,        0, 32'hCAFEF00D, "lw000_wrap"); idle("wrap");

    // Back-to-back loads, each held through its stall and DONE.
    access(0, 1, 3'b010, 32'h14, 32'h0BADF00D, 0, 32'h0,        "sw14");      idle("sw14");
    access(1, 0, 3'b010, 32'h10, 32'h0,        0, 32'hBEEFAB78, "b2b_lw10");
    access(1, 0, 3'b010, 32'h14, 32'h0,        0, 32'h0BADF00D, "b2b_lw14");
    idle("b2b");
    @(negedge clk);
    #1;
    chk("b2b/no_dup_stall", {31'b0, stallM}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
